// File: rtl/buzz_round_arbiter.sv
// buzz_round_arbiter: times each buzzer round, flags false starts, and picks one
// winner using round-robin tie-breaking while keeping saturating per-player scores.
module buzz_round_arbiter #(
   parameter int NUM_PLAYERS    = 4,
   parameter int ID_W           = 2,
   parameter int WAIT_CYCLES    = 100000000,
   parameter int TIMEOUT_CYCLES = 300000000,
   parameter int CNT_W          = 32,
   parameter int SCORE_W        = 4
) (
   input  logic                           clk_100mhz,
   input  logic                           reset,
   input  logic [NUM_PLAYERS-1:0]         press_event,
   input  logic                           start_round,
   input  logic                           clear_scores,
   output logic [2:0]                     state,
   output logic                           go_lamp,
   output logic                           winner_valid,
   output logic [ID_W-1:0]                winner_id,
   output logic [NUM_PLAYERS-1:0]         foul_mask,
   output logic                           timed_out,
   output logic [NUM_PLAYERS*SCORE_W-1:0] score_flat
);
   typedef enum logic [2:0] {IDLE = 3'd0, WAIT = 3'd1, OPEN = 3'd2, RESULT = 3'd3} state_t;
   state_t st;
   logic [CNT_W-1:0] cnt;
   logic [ID_W-1:0] ptr, pick, idx;
   logic [NUM_PLAYERS-1:0] elig, fouls;
   logic [SCORE_W-1:0] cur;
   assign state = st;
   // Scan from the lowest priority upward so the highest-priority eligible player is written last.
   always_comb begin
      elig  = press_event & ~foul_mask;
      fouls = foul_mask | press_event;
      pick  = '0;
      idx   = '0;
      for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
         idx = ID_W'((int'(ptr) + k) % NUM_PLAYERS);
         if (elig[idx]) pick = idx;
      end
      cur = score_flat[pick*SCORE_W +: SCORE_W];
   end
   always_ff @(posedge clk_100mhz) begin
      if (reset) begin
         st           <= IDLE;
         cnt          <= '0;
         ptr          <= '0;
         go_lamp      <= 1'b0;
         winner_valid <= 1'b0;
         winner_id    <= '0;
         foul_mask    <= '0;
         timed_out    <= 1'b0;
         score_flat   <= '0;
      end else begin
         if ((st == IDLE || st == RESULT) && start_round) begin
            st           <= WAIT;
            cnt          <= '0;
            foul_mask    <= '0;
            winner_valid <= 1'b0;
            timed_out    <= 1'b0;
         end else if (st == WAIT) begin
            foul_mask <= fouls;
            cnt       <= cnt + 1'b1;
            if (&fouls) begin
               st        <= RESULT;
               timed_out <= 1'b1;
            end else if (cnt == CNT_W'(WAIT_CYCLES - 1)) begin
               st      <= OPEN;
               go_lamp <= 1'b1;
               cnt     <= '0;
            end
         end else if (st == OPEN) begin
            cnt <= cnt + 1'b1;
            if (|elig) begin
               st           <= RESULT;
               go_lamp      <= 1'b0;
               winner_valid <= 1'b1;
               winner_id    <= pick;
               ptr          <= (int'(pick) == NUM_PLAYERS - 1) ? '0 : pick + 1'b1;
               if (cur != '1) score_flat[pick*SCORE_W +: SCORE_W] <= cur + 1'b1;
            end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               st        <= RESULT;
               go_lamp   <= 1'b0;
               timed_out <= 1'b1;
            end
         end
         // Placed last so a coincident clear overrides the winner increment.
         if (clear_scores) score_flat <= '0;
      end
   end
endmodule

// File: tb/tb_buzz_round_arbiter.sv
// tb_buzz_round_arbiter: directed checks of round timing, fouls, tie-break, timeout,
// score saturation/clear and reset, using small timing parameters.
module tb_buzz_round_arbiter;
   logic        clk = 1'b0;
   logic        reset, start_round, clear_scores;
   logic [3:0]  press_event;
   logic [2:0]  state;
   logic        go_lamp, winner_valid, timed_out;
   logic [1:0]  winner_id;
   logic [3:0]  foul_mask;
   logic [15:0] score_flat;
   int checks = 0, failures = 0;

   buzz_round_arbiter #(
      .NUM_PLAYERS(4), .ID_W(2), .WAIT_CYCLES(10), .TIMEOUT_CYCLES(20), .CNT_W(8), .SCORE_W(4)
   ) dut (
      .clk_100mhz(clk), .reset(reset), .press_event(press_event), .start_round(start_round),
      .clear_scores(clear_scores), .state(state), .go_lamp(go_lamp), .winner_valid(winner_valid),
      .winner_id(winner_id), .foul_mask(foul_mask), .timed_out(timed_out), .score_flat(score_flat)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts a round, lets WAIT elapse, then applies p (and clr) in the first OPEN cycle.
   task automatic play(input logic [3:0] p, input logic clr);
      start_round = 1'b1;
      step();
      start_round = 1'b0;
      repeat (10) step();
      press_event  = p;
      clear_scores = clr;
      step();
      press_event  = '0;
      clear_scores = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start_round = 1'b0; clear_scores = 1'b0; press_event = '0;
      step(); step();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_go", 32'(go_lamp), 32'd0);
      chk("rst_wv", 32'(winner_valid), 32'd0);
      chk("rst_wid", 32'(winner_id), 32'd0);
      chk("rst_foul", 32'(foul_mask), 32'd0);
      chk("rst_to", 32'(timed_out), 32'd0);
      chk("rst_score", 32'(score_flat), 32'd0);
      reset = 1'b0;

      // Single round: OPEN after exactly 10 WAIT cycles, player 2 wins on the second OPEN cycle
      start_round = 1'b1;
      step();
      start_round = 1'b0;
      chk("t1_wait", 32'(state), 32'd1);
      repeat (9) step();
      chk("t1_last_wait", 32'(state), 32'd1);
      chk("t1_go_off", 32'(go_lamp), 32'd0);
      step();
      chk("t1_open", 32'(state), 32'd2);
      chk("t1_go_on", 32'(go_lamp), 32'd1);
      step();
      press_event = 4'b0100;
      step();
      press_event = '0;
      chk("t1_result", 32'(state), 32'd3);
      chk("t1_wv", 32'(winner_valid), 32'd1);
      chk("t1_wid", 32'(winner_id), 32'd2);
      chk("t1_go_after", 32'(go_lamp), 32'd0);
      chk("t1_score", 32'(score_flat), 32'h0100);
      press_event = 4'b1111;
      step();
      press_event = '0;
      chk("t1_hold_wid", 32'(winner_id), 32'd2);
      chk("t1_hold_score", 32'(score_flat), 32'h0100);

      // False start in the last WAIT cycle; player 1 ignored in OPEN, player 3 wins
      start_round = 1'b1;
      step();
      start_round = 1'b0;
      repeat (9) step();
      press_event = 4'b0010;
      step();
      press_event = '0;
      chk("t2_open", 32'(state), 32'd2);
      chk("t2_foul", 32'(foul_mask), 32'b0010);
      press_event = 4'b0010;
      step();
      chk("t2_ignored", 32'(state), 32'd2);
      press_event = 4'b1000;
      step();
      press_event = '0;
      chk("t2_result", 32'(state), 32'd3);
      chk("t2_wid", 32'(winner_id), 32'd3);
      chk("t2_foul_hold", 32'(foul_mask), 32'b0010);
      chk("t2_score", 32'(score_flat), 32'h1100);

      // Simultaneous presses from reset: pointer rotates 0,1,2
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int r = 0; r < 3; r++) begin
         play(4'b1111, 1'b0);
         chk($sformatf("t3_wid%0d", r), 32'(winner_id), 32'(r));
      end
      chk("t3_score", 32'(score_flat), 32'h0111);

      // Timeout: start_round in OPEN is ignored, RESULT exactly 20 cycles after OPEN
      start_round = 1'b1;
      step();
      start_round = 1'b0;
      repeat (10) step();
      chk("t4_open", 32'(state), 32'd2);
      start_round = 1'b1;
      step();
      start_round = 1'b0;
      repeat (18) step();
      chk("t4_still_open", 32'(state), 32'd2);
      step();
      chk("t4_result", 32'(state), 32'd3);
      chk("t4_to", 32'(timed_out), 32'd1);
      chk("t4_wv", 32'(winner_valid), 32'd0);

      // All-foul abort
      start_round = 1'b1;
      step();
      start_round = 1'b0;
      press_event = 4'b0001; step();
      press_event = 4'b0010; step();
      press_event = 4'b0100; step();
      chk("t5_wait", 32'(state), 32'd1);
      chk("t5_foul3", 32'(foul_mask), 32'b0111);
      press_event = 4'b1000; step();
      press_event = '0;
      chk("t5_result", 32'(state), 32'd3);
      chk("t5_to", 32'(timed_out), 32'd1);
      chk("t5_wv", 32'(winner_valid), 32'd0);
      chk("t5_foul", 32'(foul_mask), 32'b1111);

      // Saturation and clear coincident with a win
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 1; i <= 17; i++) begin
         play(4'b0001, 1'b0);
         if (i == 15) chk("t6_score15", 32'(score_flat), 32'h000F);
      end
      chk("t6_sat", 32'(score_flat), 32'h000F);
      chk("t6_wid", 32'(winner_id), 32'd0);
      play(4'b0001, 1'b1);
      chk("t6_clear_wv", 32'(winner_valid), 32'd1);
      chk("t6_clear", 32'(score_flat), 32'h0000);

      // Reset in OPEN together with presses; pointer was 1 before reset
      start_round = 1'b1;
      step();
      start_round = 1'b0;
      repeat (10) step();
      chk("t7_open", 32'(state), 32'd2);
      press_event = 4'b1111;
      reset = 1'b1;
      step();
      reset = 1'b0;
      press_event = '0;
      chk("t7_state", 32'(state), 32'd0);
      chk("t7_wv", 32'(winner_valid), 32'd0);
      chk("t7_go", 32'(go_lamp), 32'd0);
      chk("t7_score", 32'(score_flat), 32'h0000);
      play(4'b1111, 1'b0);
      chk("t7_ptr", 32'(winner_id), 32'd0);
      chk("t7_score1", 32'(score_flat), 32'h0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/buzz_round_arbiter.md
# buzz_round_arbiter

Round controller and first-press arbiter for the game's player buttons. It takes the one-cycle press pulses from each player's debounced button channel and runs each round: a hold-off phase, then an open phase. It detects false starts, picks a single winner with round-robin tie-breaking, and keeps per-player saturating scores. It sits between the per-button input handlers and the display/sound logic, which consume its state, go lamp and result outputs.

## Interface
- NUM_PLAYERS, 4: number of player channels (2..8).
- ID_W, 2: width of the player index; 2^ID_W >= NUM_PLAYERS.
- WAIT_CYCLES, 100000000: hold-off length in clocks (1 s at 100 MHz), >= 1.
- TIMEOUT_CYCLES, 300000000: maximum open-phase length in clocks, >= 1.
- CNT_W, 32: phase counter width; must hold max(WAIT_CYCLES, TIMEOUT_CYCLES).
- SCORE_W, 4: per-player score width.
- clk_100mhz  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- press_event  in  NUM_PLAYERS  one-cycle press pulses, bit i = player i; multiple bits may be high together.
- start_round  in  1  one-cycle pulse that starts a round.
- clear_scores  in  1  one-cycle pulse that zeroes all scores.
- state  out  3  current state code: IDLE=0, WAIT=1, OPEN=2, RESULT=3.
- go_lamp  out  1  high while in OPEN.
- winner_valid  out  1  high in RESULT when a winner exists.
- winner_id  out  ID_W  index of the winner; valid only when winner_valid=1.
- foul_mask  out  NUM_PLAYERS  players that pressed during WAIT in the current or last round.
- timed_out  out  1  high in RESULT when the round ended by timeout or because all players fouled.
- score_flat  out  NUM_PLAYERS*SCORE_W  scores; player i occupies bits [i*SCORE_W +: SCORE_W].

## Operation
- All outputs are registered.
- Reset values: state=IDLE, go_lamp=0, winner_valid=0, winner_id=0, foul_mask=0, timed_out=0, all scores=0, phase counter=0, priority pointer=0.
- IDLE
  - start_round -> WAIT.
  - On entry to WAIT: load counter=0, clear foul_mask, winner_valid and timed_out.
- WAIT
  - Every press_event bit sets the matching foul_mask bit (sticky for the round).
  - If every player is fouled, go to RESULT with timed_out=1 and no winner.
  - Otherwise, when counter reaches WAIT_CYCLES-1, go to OPEN.
  - Counter increments every cycle.
- OPEN
  - Eligible presses = press_event & ~foul_mask.
  - If any eligible press exists, go to RESULT with the winner.
  - Else, when counter reaches TIMEOUT_CYCLES-1, go to RESULT with timed_out=1.
  - Counter is reloaded to 0 on entry to OPEN.
- Tie-break when several eligible presses arrive in the same cycle:
  - Round-robin: the highest-priority player is the priority pointer, then pointer+1, and so on, wrapping modulo NUM_PLAYERS.
  - After a win, the pointer = (winner_id+1) mod NUM_PLAYERS.
- RESULT
  - Holds all outputs.
  - start_round -> WAIT (next round). There is no other exit except reset.
- Score
  - The winner's score increments in the cycle RESULT is entered.
  - It saturates at 2^SCORE_W-1 (no wrap).
- clear_scores
  - Accepted in any state.
  - Zeroes all scores next cycle.
  - If it coincides with a winner increment, the clear wins (score=0).
- start_round is ignored in WAIT and OPEN.
- press_event in IDLE or RESULT is ignored.
- Press bits at index >= NUM_PLAYERS do not exist.

## Timing
- start_round high in cycle t (IDLE or RESULT): state=WAIT at t+1.
- WAIT occupies exactly WAIT_CYCLES cycles; state=OPEN and go_lamp=1 at t+1+WAIT_CYCLES.
- A press in the last WAIT cycle is a foul. A press in the first OPEN cycle is eligible.
- Eligible press in OPEN at cycle k: state=RESULT, winner_valid=1, winner_id, score update and go_lamp=0 all at k+1.
- Timeout: OPEN lasts exactly TIMEOUT_CYCLES cycles, then RESULT.
- All-foul abort: RESULT in the cycle after the last fouling press.
- Reset asserted in any cycle (mid-WAIT, mid-OPEN, same cycle as a press or start_round) returns every register to its reset value at the next edge. Reset has priority over all inputs.

## Test plan
- Single round, small parameters (WAIT_CYCLES=10, TIMEOUT_CYCLES=20, NUM_PLAYERS=4)
  - Stimulus: start_round at t=5; player 2 press at t=17.
  - Required: OPEN at t=16; RESULT at t=18 with winner_id=2, winner_valid=1, score2=1.
- False start
  - Stimulus: player 1 presses during WAIT, then presses again in OPEN; player 3 presses later in OPEN.
  - Required: foul_mask=4'b0010; player 1's OPEN press is ignored; winner_id=3.
- Simultaneous presses
  - Stimulus: press_event=4'b1111 in the first OPEN cycle, repeated for 3 rounds from reset.
  - Required: winners 0, 1, 2 in that order.
- Timeout and all-foul
  - Stimulus: round with no press; then a round where all 4 players press during WAIT.
  - Required: timeout round reaches RESULT exactly 20 cycles after OPEN, timed_out=1, winner_valid=0. All-foul round reaches RESULT the cycle after the 4th foul, timed_out=1.
- Score saturation and clear
  - Stimulus: player 0 wins 17 rounds (SCORE_W=4).
  - Required: score0 saturates at 15. clear_scores coincident with a win gives score0=0.
- Reset mid-OPEN
  - Stimulus: assert reset during OPEN together with a press.
  - Required: state=IDLE, no winner, all scores 0 and pointer 0 at the next cycle.
